// File: rtl/down_counter.sv
// Free-running down counter with combinational terminal count and a registered wrap pulse.
// q steps once per clk edge with no stall or backpressure; DOWN_COUNTER_SATURATE_EN holds q at zero instead of wrapping.
module down_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_zero;

  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q - WIDTH'(1);
    wrap_d = at_zero;
`ifdef DOWN_COUNTER_SATURATE_EN
    // Zero is sticky until the next reset, so there is never a rollover to flag.
    wrap_d = 1'b0;
    if (at_zero) begin
      cnt_d = cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = at_zero;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: vector table, hand-timed reset sequences, randomized resets against an edge-count model.
module tb_down_counter;

`ifdef DOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       rst6;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic [5:0] q6;
  logic       tc6;
  logic       wrap6;

  int tests;
  int fails;
  int n;
  int n6;
  int wrap_cnt;

  down_counter dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .tc    (tc),
    .wrap  (wrap)
  );

  down_counter #(.WIDTH(6), .RESET_VAL(6'd5)) dut6 (
    .clk   (clk),
    .reset (rst6),
    .q     (q6),
    .tc    (tc6),
    .wrap  (wrap6)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit       rst;
    bit [3:0] q;
    bit       tc;
    bit       wrap;
  } vec_t;

  vec_t tbl [7];

  // Expected count after n clock edges since reset: reset value minus n, wrapped or clamped.
  function automatic int m_q(input int r, input int w, input int edges);
    int v;
    int m;
    m = 1 << w;
    v = r - edges;
    if (SAT) return (v < 0) ? 0 : v;
    return ((v % m) + m) % m;
  endfunction

  function automatic bit m_wrap(input int r, input int w, input int edges);
    return !SAT && edges >= 1 && m_q(r, w, edges) == (1 << w) - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int edges);
    int e;
    e = m_q(15, 4, edges);
    check({tag, ".q"},    32'(q),    32'(e));
    check({tag, ".tc"},   32'(tc),   32'(e == 0));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap(15, 4, edges)));
  endtask

  task automatic check_dut6(input string tag, input int edges);
    int e;
    e = m_q(5, 6, edges);
    check({tag, ".q6"},    32'(q6),    32'(e));
    check({tag, ".tc6"},   32'(tc6),   32'(e == 0));
    check({tag, ".wrap6"}, 32'(wrap6), 32'(m_wrap(5, 6, edges)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{rst: 1'b0, q: 4'hE, tc: 1'b0, wrap: 1'b0};
    tbl[1] = '{rst: 1'b0, q: 4'hD, tc: 1'b0, wrap: 1'b0};
    tbl[2] = '{rst: 1'b0, q: 4'hC, tc: 1'b0, wrap: 1'b0};
    tbl[3] = '{rst: 1'b0, q: 4'hB, tc: 1'b0, wrap: 1'b0};
    tbl[4] = '{rst: 1'b0, q: 4'hA, tc: 1'b0, wrap: 1'b0};
    tbl[5] = '{rst: 1'b1, q: 4'hF, tc: 1'b0, wrap: 1'b0};
    tbl[6] = '{rst: 1'b1, q: 4'hF, tc: 1'b0, wrap: 1'b0};

    reset = 1'b0;
    rst6  = 1'b1;

    // Reset pulse between edges: asserted at 20ns, released at 40ns.
    #20 reset = 1'b1;
    #1;
    check("async_assert.q",    32'(q),    32'hF);
    check("async_assert.tc",   32'(tc),   32'h0);
    check("async_assert.wrap", 32'(wrap), 32'h0);
    #19 reset = 1'b0;
    #1;
    check("release_no_edge.q", 32'(q), 32'hF);

    for (int i = 0; i < 5; i++) begin
      reset = tbl[i].rst;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.q", i),    32'(q),    32'(tbl[i].q));
      check($sformatf("tbl%0d.tc", i),   32'(tc),   32'(tbl[i].tc));
      check($sformatf("tbl%0d.wrap", i), 32'(wrap), 32'(tbl[i].wrap));
    end

    // Reassert while q = A, between edges, then hold across two edges.
    #4 reset = 1'b1;
    #1;
    check("reassert_at_A.q", 32'(q), 32'hF);
    check("reassert_at_A.tc", 32'(tc), 32'h0);
    for (int i = 5; i < 7; i++) begin
      reset = tbl[i].rst;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.q", i),    32'(q),    32'(tbl[i].q));
      check($sformatf("tbl%0d.wrap", i), 32'(wrap), 32'(tbl[i].wrap));
    end

    // Free run 16 edges from F.
    reset    = 1'b0;
    n        = 0;
    wrap_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      n++;
      check_dut($sformatf("free%0d", i), n);
      if (wrap === 1'b1) wrap_cnt++;
    end
    check("free_run.end_q", 32'(q), SAT ? 32'h0 : 32'hF);
    check("free_run.wrap_pulses", 32'(wrap_cnt), SAT ? 32'd0 : 32'd1);

    // Randomized reset pulses, some landing between edges.
    reset = 1'b1;
    #1;
    n = 0;
    check_dut("rand_start", n);
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 11) == 0);
      #1;
      if (reset) n = 0;
      check_dut($sformatf("rand%0d.pre", i), n);
      @(posedge clk);
      #1;
      if (!reset) n++;
      check_dut($sformatf("rand%0d", i), n);
    end

    // Wider instance with a non-default reset value.
    check("w6_held.q", 32'(q6), 32'd5);
    rst6 = 1'b0;
    n6   = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n6++;
      check_dut6($sformatf("w6_%0d", i), n6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
